fft64_stage_ctrl: RTL

Sequencer for the 64-point radix-4 FFT built around the R64 butterfly stage (16 parallel radix-4 butterflies over a 64-entry complex sample buffer). It accepts 64 input samples over a valid/ready stream, steps the butterfly stage through NUM_STAGES passes, waits out the butterfly pipeline latency on each pass and commits results back to the buffer. It then drains the buffer in digit-reversed order over a valid/ready output stream. The block holds only control: the buffer and butterfly datapath are external and driven by this block's strobes.

---
 rtl/fft64_stage_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fft64_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft64_stage_ctrl
//
// Control sequencer for a 64-point radix-4 FFT built around an external R64
// butterfly stage (16 radix-4 butterflies over a 64-entry complex buffer).
// The block carries no sample data. It only produces strobes and addresses for
// the external buffer and butterfly datapath.
//
// A transform runs in three phases:
//   LOAD    accept 64 samples over in_valid/in_ready and write them to
//           buffer[load_cnt]
//   compute for each pass: ISSUE (bf_start), WAIT out BFLY_LAT-1 cycles,
//           then CAPTURE (bf_capture writes all 64 results back)
//   DRAIN   present 64 read addresses over out_valid/out_ready, in base-4
//           digit-reversed or natural order
//
// Parameters
//   BFLY_LAT    cycles from bf_start to valid butterfly outputs (1..15)
//   NUM_STAGES  butterfly passes per transform (1..4)
//   DIGIT_REV   1: out_addr is the base-4 digit reversal of the drain count
//               0: out_addr is the drain count
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; returns to LOAD immediately
//   in_valid   input sample present
//   in_last    marks the 64th input sample (used only for framing checks)
//   in_ready   high throughout LOAD
//   buf_we     write one input sample at buf_waddr
//   buf_waddr  buffer write address (load count)
//   bf_start   one-cycle pulse: butterfly stage samples its inputs
//   bf_stage   current pass index, valid from ISSUE through CAPTURE
//   bf_capture one-cycle pulse: commit the butterfly outputs to the buffer
//   out_valid  output address present (DRAIN only)
//   out_ready  downstream accepts the output sample
//   out_addr   buffer read address for the output sample
//   out_last   marks the 64th output sample
//   busy       high in every state except LOAD
//   done       registered one-cycle pulse after the final drain handshake
//   err        sticky: some accepted beat had in_last != (load_cnt == 63)
// -----------------------------------------------------------------------------
module fft64_stage_ctrl #(
  parameter int unsigned BFLY_LAT   = 4,
  parameter int unsigned NUM_STAGES = 3,
  parameter bit          DIGIT_REV  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       buf_we,
  output logic [5:0] buf_waddr,
  output logic       bf_start,
  output logic [1:0] bf_stage,
  output logic       bf_capture,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_addr,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  // WAIT spans BFLY_LAT-1 cycles, counted down from BFLY_LAT-2 to 0, so
  // that bf_capture lands exactly BFLY_LAT cycles after bf_start.
  localparam logic [3:0] WAIT_INIT  = (BFLY_LAT >= 2) ? 4'(BFLY_LAT - 2) : 4'd0;
  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

  state_t     state_q,    state_d;
  logic [5:0] load_cnt_q, load_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] stage_q,    stage_d;
  logic [5:0] out_cnt_q,  out_cnt_d;
  logic       done_q,     done_d;
  logic       err_q,      err_d;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      wait_cnt_q <= '0;
      stage_q    <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      stage_q    <= stage_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and output decodes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    wait_cnt_d = wait_cnt_q;
    stage_d    = stage_q;
    out_cnt_d  = out_cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;

    in_ready   = 1'b0;
    buf_we     = 1'b0;
    bf_start   = 1'b0;
    bf_capture = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we     = 1'b1;
          load_cnt_d = load_cnt_q + 6'd1;
          // in_last is only checked, never obeyed: the load length is fixed
          // at 64 beats regardless of framing.
          if (in_last != (load_cnt_q == 6'd63)) begin
            err_d = 1'b1;
          end
          if (load_cnt_q == 6'd63) begin
            stage_d = '0;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        bf_start = 1'b1;
        if (BFLY_LAT == 1) begin
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = WAIT_INIT;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      S_CAPTURE: begin
        bf_capture = 1'b1;
        if (stage_q == LAST_STAGE) begin
          out_cnt_d = '0;
          state_d   = S_DRAIN;
        end else begin
          stage_d = stage_q + 2'd1;
          state_d = S_ISSUE;
        end
      end

      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (out_cnt_q == 6'd63);
        if (out_ready) begin
          out_cnt_d = out_cnt_q + 6'd1;
          if (out_cnt_q == 6'd63) begin
            done_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // load_cnt and out_cnt rest at zero outside their phases, so these decodes
  // read 0 whenever the corresponding strobe is idle.
  assign buf_waddr = load_cnt_q;
  assign out_addr  = DIGIT_REV ? {out_cnt_q[1:0], out_cnt_q[3:2], out_cnt_q[5:4]}
                               : out_cnt_q;
  assign bf_stage  = stage_q;
  assign busy      = (state_q != S_LOAD);
  assign done      = done_q;
  assign err       = err_q;

endmodule
